// File: rtl/pad_event_gen_pkg.sv
// Shared constants for the gamepad path: button bit map, direction codes and
// the direction FSM state type. Imported by the reader, pad_event_gen and world.
package pad_event_gen_pkg;

   localparam int unsigned NUM_BUTTONS = 11;

   // Bit positions in the level-sensitive button vector
   localparam int unsigned BTN_UP    = 0;
   localparam int unsigned BTN_DOWN  = 1;
   localparam int unsigned BTN_LEFT  = 2;
   localparam int unsigned BTN_RIGHT = 3;
   localparam int unsigned BTN_A     = 4;
   localparam int unsigned BTN_B     = 5;
   localparam int unsigned BTN_C     = 6;
   localparam int unsigned BTN_START = 7;
   localparam int unsigned BTN_X     = 8;
   localparam int unsigned BTN_Y     = 9;
   localparam int unsigned BTN_Z     = 10;

   // Encoding carried on move_dir
   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_RIGHT = 2'b11;

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StDelay  = 2'b01,
      StRepeat = 2'b10
   } dir_state_e;

endpackage

// File: rtl/pad_event_gen_if.sv
// Button/event bundle between the gamepad reader, pad_event_gen and world.
//   master : pad_event_gen side - takes buttons_in, drives the debounced events
//   slave  : reader/world side  - drives buttons_in, consumes the events
// Signals:
//   buttons_in     raw button levels, 1 = pressed
//   buttons_stable debounced levels
//   press_pulse    one-cycle pulse per stable 0->1
//   release_pulse  one-cycle pulse per stable 1->0
//   move_valid     one-cycle move command strobe
//   move_dir       direction of the move, held between strobes
interface pad_event_gen_if;
   import pad_event_gen_pkg::*;

   logic [NUM_BUTTONS-1:0] buttons_in;
   logic [NUM_BUTTONS-1:0] buttons_stable;
   logic [NUM_BUTTONS-1:0] press_pulse;
   logic [NUM_BUTTONS-1:0] release_pulse;
   logic                   move_valid;
   logic [1:0]             move_dir;

   modport master (
      input  buttons_in,
      output buttons_stable,
      output press_pulse,
      output release_pulse,
      output move_valid,
      output move_dir
   );

   modport slave (
      output buttons_in,
      input  buttons_stable,
      input  press_pulse,
      input  release_pulse,
      input  move_valid,
      input  move_dir
   );

endinterface

// File: rtl/debounce_bit.sv
// One-bit two-flop synchronizer followed by a disagreement-counting debouncer.
// Ports:
//   i_clk     clock
//   i_rst_n   asynchronous active-low reset
//   i_raw     raw asynchronous level
//   o_stable  debounced level; flips after DEBOUNCE_CYCLES consecutive
//             cycles of the synchronized input disagreeing with it
module debounce_bit #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_raw,
   output logic o_stable
);

   // +1 keeps the width non-zero when DEBOUNCE_CYCLES is 1
   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

   logic            r_sync1;
   logic            r_sync2;
   logic            r_stable;
   logic [CntW-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CntW'(DEBOUNCE_CYCLES - 1)) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CntW'(1);
         end
      end
   end

   assign o_stable = r_stable;

endmodule

// File: rtl/pad_event_gen.sv
// Turns the gamepad reader's raw button vector into debounced levels,
// registered press/release pulses and a hold-to-repeat direction move stream.
// Ports:
//   clock_50   system clock
//   reset_key  asynchronous active-low reset
//   pad        pad_event_gen_if.master (buttons_in in; stable/pulses/moves out)
module pad_event_gen
   import pad_event_gen_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 5000000
) (
   input  logic             clock_50,
   input  logic             reset_key,
   pad_event_gen_if.master  pad
);

   localparam int unsigned MaxRep = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                   : REPEAT_PERIOD;
   localparam int unsigned TimerW = $clog2(MaxRep + 1);

   logic [NUM_BUTTONS-1:0] w_stable;
   logic [NUM_BUTTONS-1:0] r_stable_d;
   logic [NUM_BUTTONS-1:0] r_press;
   logic [NUM_BUTTONS-1:0] r_release;

   dir_state_e             r_state;
   dir_state_e             w_state_nx;
   logic [TimerW-1:0]      r_timer;
   logic [TimerW-1:0]      w_timer_nx;
   logic                   r_move_valid;
   logic                   w_move_valid_nx;
   logic [1:0]             r_move_dir;
   logic [1:0]             w_move_dir_nx;

   logic                   w_dir_any;
   logic [1:0]             w_dir_active;

   for (genvar gi = 0; gi < int'(NUM_BUTTONS); gi++) begin : g_db
      debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .i_clk    (clock_50),
         .i_rst_n  (reset_key),
         .i_raw    (pad.buttons_in[gi]),
         .o_stable (w_stable[gi])
      );
   end

   // Edge pulses lag the stable change by one cycle
   always_ff @(posedge clock_50 or negedge reset_key) begin
      if (!reset_key) begin
         r_stable_d <= '0;
         r_press    <= '0;
         r_release  <= '0;
      end else begin
         r_stable_d <= w_stable;
         r_press    <= w_stable & ~r_stable_d;
         r_release  <= ~w_stable & r_stable_d;
      end
   end

   // Fixed priority up > down > left > right
   always_comb begin
      w_dir_any    = 1'b1;
      w_dir_active = DIR_UP;
      if (w_stable[BTN_UP]) begin
         w_dir_active = DIR_UP;
      end else if (w_stable[BTN_DOWN]) begin
         w_dir_active = DIR_DOWN;
      end else if (w_stable[BTN_LEFT]) begin
         w_dir_active = DIR_LEFT;
      end else if (w_stable[BTN_RIGHT]) begin
         w_dir_active = DIR_RIGHT;
      end else begin
         w_dir_any = 1'b0;
      end
   end

   // r_move_dir doubles as the last issued direction for change detection
   always_comb begin
      w_state_nx      = r_state;
      w_timer_nx      = r_timer;
      w_move_valid_nx = 1'b0;
      w_move_dir_nx   = r_move_dir;
      unique case (r_state)
         StIdle: begin
            if (w_dir_any) begin
               w_move_valid_nx = 1'b1;
               w_move_dir_nx   = w_dir_active;
               w_timer_nx      = TimerW'(REPEAT_DELAY - 1);
               w_state_nx      = StDelay;
            end
         end
         StDelay, StRepeat: begin
            if (!w_dir_any) begin
               w_state_nx = StIdle;
            end else if (w_dir_active != r_move_dir) begin
               // A direction change restarts the full delay, even on a timer expiry cycle
               w_move_valid_nx = 1'b1;
               w_move_dir_nx   = w_dir_active;
               w_timer_nx      = TimerW'(REPEAT_DELAY - 1);
               w_state_nx      = StDelay;
            end else if (r_timer == '0) begin
               w_move_valid_nx = 1'b1;
               w_move_dir_nx   = w_dir_active;
               w_timer_nx      = TimerW'(REPEAT_PERIOD - 1);
               w_state_nx      = StRepeat;
            end else begin
               w_timer_nx = r_timer - TimerW'(1);
            end
         end
         default: begin
            w_state_nx = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock_50 or negedge reset_key) begin
      if (!reset_key) begin
         r_state      <= StIdle;
         r_timer      <= '0;
         r_move_valid <= 1'b0;
         r_move_dir   <= 2'b00;
      end else begin
         r_state      <= w_state_nx;
         r_timer      <= w_timer_nx;
         r_move_valid <= w_move_valid_nx;
         r_move_dir   <= w_move_dir_nx;
      end
   end

   assign pad.buttons_stable = w_stable;
   assign pad.press_pulse    = r_press;
   assign pad.release_pulse  = r_release;
   assign pad.move_valid     = r_move_valid;
   assign pad.move_dir       = r_move_dir;

endmodule

// File: doc/pad_event_gen.md
Name: pad_event_gen

Overview:
- Sits between the gamepad reader (`controller`) and `world`.
- Consumes the reader's 11-bit level-sensitive button vector and produces debounced, edge-qualified events the world logic can act on directly:
  - single-cycle press/release pulses per button;
  - one direction-move stream with hold-to-repeat for cursor and robot stepping.
- All logic runs in the clock_50 domain.

Parameters:
- NUM_BUTTONS, 11, width of button vector (fixed bit map below).
- DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronized input must disagree with the stable state before the stable state flips (10 ms at 50 MHz); minimum 1.
- REPEAT_DELAY, 25000000, cycles from the first move to the first auto-repeat (500 ms); minimum 1.
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeats (100 ms); minimum 1.

Ports:
- clock_50  in  1  system clock, 50 MHz.
- reset_key  in  1  reset; one clock, reset asynchronous and active-low.
- buttons_in  in  NUM_BUTTONS  raw levels from the gamepad reader, 1 = pressed; asynchronous to clock_50 as far as this block is concerned.
- buttons_stable  out  NUM_BUTTONS  debounced level, 1 = pressed.
- press_pulse  out  NUM_BUTTONS  one-cycle pulse on each stable 0->1.
- release_pulse  out  NUM_BUTTONS  one-cycle pulse on each stable 1->0.
- move_valid  out  1  one-cycle pulse: a move command is issued this cycle.
- move_dir  out  2  direction qualified by move_valid: 00 up, 01 down, 10 left, 11 right; holds last value otherwise.

Behaviour:
- **Bit map:** 0 up, 1 down, 2 left, 3 right, 4 A, 5 B, 6 C, 7 start, 8 X, 9 Y, 10 Z.
- **Reset (reset_key=0, asynchronous):**
  - All synchronizer flops, counters, buttons_stable, press_pulse, release_pulse, move_valid and move_dir go to 0.
  - FSM goes to IDLE.
  - A button held through reset is reported as a fresh press after release of reset plus the normal latency.
- **Synchronizer:** two flops per bit.
- **Debounce, per bit:**
  - The counter increments each cycle that sync != stable, and clears to 0 on any cycle sync == stable.
  - When the counter == DEBOUNCE_CYCLES-1 and sync != stable: stable <= sync, counter <= 0.
  - Raw-to-stable latency = 2 + DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never reach stable.
- **Edges:** press_pulse and release_pulse are registered and assert the cycle after stable changes, for exactly one cycle. Multiple bits may pulse in the same cycle.
- **Active direction:** the highest-priority stable-pressed direction, with priority up > down > left > right; "none" if no direction bit is stable-pressed.
- **Direction FSM:**
  - States: IDLE, DELAY, REPEAT.
  - Repeat timer is a down-counter wide enough for max(REPEAT_DELAY, REPEAT_PERIOD).
  - Transitions:
    - IDLE: active != none -> issue move(active), timer <= REPEAT_DELAY-1, go DELAY.
    - DELAY or REPEAT, active == none -> go IDLE, no move.
    - DELAY or REPEAT, active differs from last issued dir -> issue move(new), timer <= REPEAT_DELAY-1, go DELAY.
    - DELAY, timer == 0 -> issue move(active), timer <= REPEAT_PERIOD-1, go REPEAT.
    - REPEAT, timer == 0 -> issue move(active), timer <= REPEAT_PERIOD-1, stay REPEAT.
    - Otherwise decrement timer.
  - The "direction changed" check takes precedence over timer expiry in the same cycle.
  - The first move_valid coincides with the press_pulse of its direction bit.
  - Repeats are spaced exactly REPEAT_DELAY, then REPEAT_PERIOD, cycles apart.
- **Opposite directions:** not special-cased. Priority alone resolves which direction is active.
- **Non-direction buttons:** never produce move_valid.

Decomposition:
- **Shared package:**
  - button index constants BTN_UP..BTN_Z;
  - direction codes DIR_UP/DOWN/LEFT/RIGHT;
  - FSM state enum (IDLE, DELAY, REPEAT);
  - NUM_BUTTONS = 11.
  
  The reader and `world` reuse these constants.
- **Sub-module:** debounce_bit, holding the synchronizer, counter and stable flop for one bit, parameterised by DEBOUNCE_CYCLES. It is instantiated NUM_BUTTONS times via generate.
- Edge detection and the direction FSM live in the parent.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- **Clean press:**
  - Stimulus: raise buttons_in[4] at cycle 0 and hold.
  - Required response: buttons_stable[4]=1 at cycle 6; press_pulse[4]=1 only at cycle 7; no move_valid.
- **Glitch rejection:**
  - Stimulus: pulse buttons_in[7] high for 3 cycles.
  - Required response: buttons_stable, press_pulse and release_pulse stay 0.
  - Stimulus: pulse it for 4 cycles.
  - Required response: press_pulse[7], then release_pulse[7] a few cycles later.
- **Auto-repeat:**
  - Stimulus: hold buttons_in[3] (right) for 40 cycles.
  - Required response: move_valid with dir 11 at cycle 7, then cycles 17, 20, 23, 26, ...
  - Stimulus: release.
  - Required response: repeats stop; release_pulse[3] fires.
- **Priority/change:**
  - Stimulus: hold left; when in REPEAT, additionally press up.
  - Required response: move_valid dir 00 the cycle up becomes stable; next move is 10 cycles later, still dir 00.
  - Stimulus: release up while left is still held.
  - Required response: immediate move dir 10.
- **Simultaneous press:**
  - Stimulus: raise up, down and A in the same cycle.
  - Required response: press_pulse[0], [1] and [4] in the same cycle; a single move_valid dir 00.
- **Reset mid-repeat:**
  - Stimulus: assert reset_key=0 during REPEAT, right held.
  - Required response: all outputs 0 asynchronously.
  - Stimulus: deassert reset with right still held.
  - Required response: press_pulse[3] and move dir 11 return 7 cycles after deassertion.
